// File: rtl/ftdi_scheduler.sv
// Bus arbiter for the FTDI async-FIFO block: bounded read/write bursts with round-robin,
// read watermark throttling, a turnaround gap on every grant end, and one-cycle flush.
module ftdi_scheduler #(
   parameter int RD_BURST = 64,
   parameter int WR_BURST = 64,
   parameter int HIGH_WM  = 960,
   parameter int TURN_CYC = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        clear_req,
   input  logic        rxf,
   input  logic        txe,
   input  logic        rdq_full,
   input  logic        wrq_empty,
   input  logic [9:0]  qsize,
   input  logic        ftdi_rd,
   input  logic        ftdi_wr,
   output logic        rd_en,
   output logic        wr_en,
   output logic        clear,
   output logic        dir,
   output logic        busy,
   output logic [15:0] rd_bytes,
   output logic [15:0] wr_bytes
);

   localparam int MAXB   = (RD_BURST > WR_BURST) ? RD_BURST : WR_BURST;
   localparam int BW_RAW = $clog2(MAXB + 1);
   localparam int BW     = (BW_RAW < 7) ? 7 : BW_RAW;
   localparam int BW1    = BW + 1;
   localparam int TW_RAW = $clog2(TURN_CYC + 1);
   localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

   localparam logic [BW:0]    RD_END    = BW1'(RD_BURST);
   localparam logic [BW:0]    WR_END    = BW1'(WR_BURST);
   localparam logic [10:0]    WM        = 11'(HIGH_WM);
   localparam logic [TW-1:0]  TURN_LOAD = TW'(TURN_CYC - 1);

   typedef enum logic [2:0] {IDLE, READ, WRITE, TURN, FLUSH} state_t;

   state_t         state, state_n;
   logic           rd_q, wr_q;
   logic [BW-1:0]  bcnt;
   logic [TW-1:0]  tcnt;
   logic           rd_ok, wr_ok, rd_done, wr_done;
   logic [BW:0]    bcnt_inc;

   assign rd_ok    = enable & ~rxf & ~rdq_full & ({1'b0, qsize} < WM);
   assign wr_ok    = enable & ~txe & ~wrq_empty;
   assign rd_done  = ftdi_rd & ~rd_q;
   assign wr_done  = ftdi_wr & ~wr_q;
   assign bcnt_inc = {1'b0, bcnt} + {{BW{1'b0}}, 1'b1};

   assign rd_en = (state == READ);
   assign wr_en = (state == WRITE);
   assign clear = (state == FLUSH);
   assign busy  = (state != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            // Contended: go opposite to the last grant.
            if (rd_ok && (!wr_ok || !dir)) state_n = READ;
            else if (wr_ok)                state_n = WRITE;
         end
         READ:    if ((rd_done && bcnt_inc == RD_END) || !rd_ok) state_n = TURN;
         WRITE:   if ((wr_done && bcnt_inc == WR_END) || !wr_ok) state_n = TURN;
         TURN:    if (tcnt == '0) state_n = IDLE;
         FLUSH:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (clear_req) state_n = FLUSH;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_q     <= 1'b1;
         wr_q     <= 1'b1;
         bcnt     <= '0;
         tcnt     <= '0;
         dir      <= 1'b0;
         rd_bytes <= '0;
         wr_bytes <= '0;
      end else begin
         rd_q <= ftdi_rd;
         wr_q <= ftdi_wr;
         if (state == FLUSH) begin
            bcnt     <= '0;
            tcnt     <= '0;
            dir      <= 1'b0;
            rd_bytes <= '0;
            wr_bytes <= '0;
         end else begin
            // Completions count in every state so late bytes landing in TURN are kept.
            if (rd_done) rd_bytes <= rd_bytes + 16'd1;
            if (wr_done) wr_bytes <= wr_bytes + 16'd1;

            if (state == IDLE && (state_n == READ || state_n == WRITE))
               bcnt <= '0;
            else if ((state == READ && rd_done) || (state == WRITE && wr_done))
               bcnt <= bcnt + 1'b1;

            if (state != TURN && state_n == TURN)
               tcnt <= TURN_LOAD;
            else if (state == TURN && tcnt != '0)
               tcnt <= tcnt - 1'b1;

            if (state == IDLE && state_n == READ)       dir <= 1'b1;
            else if (state == IDLE && state_n == WRITE) dir <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ftdi_scheduler.sv
// Scoreboarded bench for ftdi_scheduler: expected grant/clear events are queued by the
// stimulus and popped by a monitor; an FTDI strobe model produces byte completions.
module tb_ftdi_scheduler;

   localparam int RD_BURST = 4;
   localparam int WR_BURST = 4;
   localparam int HIGH_WM  = 960;
   localparam int TURN_CYC = 4;

   localparam logic [7:0] EV_R = 8'd1;
   localparam logic [7:0] EV_W = 8'd2;
   localparam logic [7:0] EV_C = 8'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0, clear_req = 1'b0;
   logic        rxf = 1'b1, txe = 1'b1, rdq_full = 1'b0, wrq_empty = 1'b1;
   logic [9:0]  qsize = '0;
   logic        ftdi_rd = 1'b1, ftdi_wr = 1'b1;
   logic        rd_en, wr_en, clear, dir, busy;
   logic [15:0] rd_bytes, wr_bytes;

   int nchk = 0, nerr = 0;
   logic [7:0] exp_q[$];

   ftdi_scheduler #(
      .RD_BURST(RD_BURST), .WR_BURST(WR_BURST), .HIGH_WM(HIGH_WM), .TURN_CYC(TURN_CYC)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .clear_req(clear_req),
      .rxf(rxf), .txe(txe), .rdq_full(rdq_full), .wrq_empty(wrq_empty), .qsize(qsize),
      .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr), .rd_en(rd_en), .wr_en(wr_en), .clear(clear),
      .dir(dir), .busy(busy), .rd_bytes(rd_bytes), .wr_bytes(wr_bytes)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // FTDI model: strobe low two cycles, rising edge completes the byte, then one WAIT cycle.
   int rph = 0, wph = 0, rd_starts = 0, wr_starts = 0, rd_cmp = 0, wr_cmp = 0;
   always @(negedge clock) begin
      if (reset) begin
         ftdi_rd = 1'b1; ftdi_wr = 1'b1; rph = 0; wph = 0;
         rd_starts = 0; wr_starts = 0; rd_cmp = 0; wr_cmp = 0;
      end else begin
         case (rph)
            0: if (rd_en && !rxf) begin ftdi_rd = 1'b0; rph = 1; rd_starts++; end
            1: rph = 2;
            2: begin ftdi_rd = 1'b1; rd_cmp++; rph = 3; end
            default: rph = 0;
         endcase
         case (wph)
            0: if (wr_en && !txe) begin ftdi_wr = 1'b0; wph = 1; wr_starts++; end
            1: wph = 2;
            2: begin ftdi_wr = 1'b1; wr_cmp++; wph = 3; end
            default: wph = 0;
         endcase
      end
   end

   // Monitor: pops an expectation on every grant or clear rising edge.
   int gap = 1000, ngrants = 0;
   logic prev_rd = 1'b0, prev_wr = 1'b0, prev_clr = 1'b0;
   logic [7:0] mon_ev, mon_exp;
   always @(negedge clock) begin
      if (reset) begin
         prev_rd = 1'b0; prev_wr = 1'b0; prev_clr = 1'b0; gap = 1000;
      end else begin
         if ((rd_en && !prev_rd) || (wr_en && !prev_wr) || (clear && !prev_clr)) begin
            mon_ev = clear ? EV_C : (rd_en ? EV_R : EV_W);
            if (exp_q.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL unexpected_event: got %0d, required none", mon_ev);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("event_order", mon_ev, mon_exp);
            end
            if (mon_ev != EV_C) begin
               ngrants++;
               chk("turn_gap_ge_turn_cyc", (gap >= TURN_CYC), 1);
               chk("no_overlap", (rd_en && wr_en), 0);
            end
         end
         if (rd_en || wr_en) gap = 0;
         else if (clear)     gap = 1000;
         else                gap++;
         prev_rd = rd_en; prev_wr = wr_en; prev_clr = clear;
      end
   end

   task automatic wait_sig(input int sel, input int val, input string name);
      int cur;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         case (sel)
            0:       cur = int'(rd_bytes);
            1:       cur = int'(wr_bytes);
            2:       cur = int'(rd_en);
            3:       cur = int'(wr_en);
            default: cur = int'(busy);
         endcase
         if (cur == val) return;
      end
      nchk++; nerr++;
      $display("FAIL %s: timeout, required %0d", name, val);
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1; enable = 1'b0; clear_req = 1'b0; rxf = 1'b1; txe = 1'b1;
      rdq_full = 1'b0; wrq_empty = 1'b1; qsize = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   int found, g0;

   initial begin
      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_clear", clear, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dir", dir, 0);
      chk("rst_rd_bytes", rd_bytes, 0);
      chk("rst_wr_bytes", wr_bytes, 0);
      @(posedge clock); #1 reset = 1'b0;

      // Read-only bursts
      @(posedge clock); #1;
      enable = 1'b1; rxf = 1'b0;
      exp_q.push_back(EV_R); exp_q.push_back(EV_R);
      wait_sig(0, 4, "rd_first_burst");
      chk("rd_en_after_burst", rd_en, 0);
      chk("busy_in_turn", busy, 1);
      chk("rd_starts_burst", rd_starts, 4);
      chk("dir_read", dir, 1);
      repeat (3) @(negedge clock);
      chk("rd_en_in_turn", rd_en, 0);
      chk("rd_starts_no_extra", rd_starts, 4);
      wait_sig(2, 1, "rd_second_grant");
      @(posedge clock); #1 rxf = 1'b1;
      wait_sig(4, 0, "rd_idle");
      repeat (6) @(posedge clock);
      #1 chk("rd_bytes_total", rd_bytes, rd_cmp);

      // Contention from reset: R W R W
      do_reset();
      rxf = 1'b0; txe = 1'b0; wrq_empty = 1'b0; enable = 1'b1;
      exp_q.push_back(EV_R); exp_q.push_back(EV_W);
      exp_q.push_back(EV_R); exp_q.push_back(EV_W);
      g0 = ngrants; found = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clock); #1;
         if (ngrants >= g0 + 4) begin found = 1; break; end
      end
      chk("cont_four_grants", found, 1);
      enable = 1'b0;
      wait_sig(4, 0, "cont_idle");
      repeat (6) @(posedge clock);
      #1;
      chk("cont_rd_bytes", rd_bytes, 8);
      chk("cont_rd_model", rd_bytes, rd_cmp);
      chk("cont_wr_model", wr_bytes, wr_cmp);

      // Watermark
      do_reset();
      enable = 1'b1; rxf = 1'b0; qsize = 10'd960;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("wm_block_rd_en", rd_en, 0);
      end
      chk("wm_block_busy", busy, 0);
      @(posedge clock); #1;
      qsize = 10'd959; exp_q.push_back(EV_R);
      @(negedge clock); chk("wm_rd_en_cycle1", rd_en, 0);
      @(negedge clock); chk("wm_rd_en_cycle2", rd_en, 1);
      @(posedge clock); #1;
      rxf = 1'b1; qsize = '0;
      wait_sig(4, 0, "wm_idle");

      // Mid-burst eligibility loss on write
      do_reset();
      enable = 1'b1; rxf = 1'b1; txe = 1'b0; wrq_empty = 1'b0;
      exp_q.push_back(EV_W);
      wait_sig(1, 1, "loss_first_byte");
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (!ftdi_wr) begin found = 1; break; end
      end
      chk("loss_second_start", found, 1);
      txe = 1'b1;
      @(negedge clock); chk("loss_wr_en_still", wr_en, 1);
      @(negedge clock); chk("loss_wr_en_drop", wr_en, 0);
      wait_sig(4, 0, "loss_idle");
      repeat (4) @(negedge clock);
      chk("loss_wr_bytes", wr_bytes, 2);
      chk("loss_wr_starts", wr_starts, 2);

      // Flush mid-read
      do_reset();
      enable = 1'b1; rxf = 1'b0; txe = 1'b1; wrq_empty = 1'b0;
      exp_q.push_back(EV_R);
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock); #1;
         if (rd_bytes == 16'd2) begin found = 1; break; end
      end
      chk("flush_reach_two", found, 1);
      clear_req = 1'b1; txe = 1'b0;
      exp_q.push_back(EV_C); exp_q.push_back(EV_R);
      @(negedge clock); chk("flush_rd_en_before", rd_en, 1);
      @(posedge clock); #1 clear_req = 1'b0;
      @(negedge clock);
      chk("flush_clear_on", clear, 1);
      chk("flush_rd_en_off", rd_en, 0);
      @(negedge clock);
      chk("flush_clear_once", clear, 0);
      chk("flush_rd_bytes", rd_bytes, 0);
      chk("flush_wr_bytes", wr_bytes, 0);
      chk("flush_dir", dir, 0);
      chk("flush_idle", busy, 0);
      wait_sig(2, 1, "flush_next_read");
      @(posedge clock); #1;
      rxf = 1'b1; txe = 1'b1;
      wait_sig(4, 0, "flush_end_idle");

      // Async reset mid-write
      do_reset();
      enable = 1'b1; rxf = 1'b1; txe = 1'b0; wrq_empty = 1'b0;
      exp_q.push_back(EV_W);
      wait_sig(1, 1, "arst_first_byte");
      chk("arst_wr_en_before", wr_en, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_wr_en", wr_en, 0);
      chk("arst_busy", busy, 0);
      chk("arst_wr_bytes", wr_bytes, 0);
      chk("arst_rd_bytes", rd_bytes, 0);
      do_reset();
      repeat (4) @(negedge clock);

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
